f2c_dma_writer: RTL
===================

Name: f2c_dma_writer

Overview:
- FPGA-side FPGA->CPU DMA engine. Consumes a 64-bit data stream and packs it into fixed-size memory-write TLPs.
- Fills a ring of chunks in host memory. After each completed chunk it DMAs its write pointer to the host metrics buffer.
- Sits between the application data source and the PCIe TX TLP transceiver.
- Register-side inputs (buffer bases, host read pointer, enable) come from the BAR register file.

Parameters:
- TLP_QWS, 16, data QWs per TLP (128-byte payload).
- TLPS_PER_CHUNK, 32, TLPs per chunk (4096-byte chunk).
- NUM_CHUNKS, 4, ring depth in chunks; power of 2. PTR_W = log2(NUM_CHUNKS).

Ports:
- clk_in  in  1  system clock; single clock domain.
- rstn  in  1  reset, asynchronous, active-low.
- cfgBusDev_in  in  16  requester ID for TLP headers.
- enable_in  in  1  DMA enable.
- f2cBase_in  in  29  host ring base, QW address (byte address / 8).
- mtrBase_in  in  29  host metrics base, QW address; wrPtr is written here.
- rdPtr_in  in  PTR_W  host read pointer (chunk index).
- wrPtr_out  out  PTR_W  current write pointer.
- f2cData_in  in  64  source data.
- f2cValid_in  in  1  source valid.
- f2cReady_out  out  1  source ready.
- txData_out  out  64  TLP beat.
- txValid_out  out  1  TLP beat valid.
- txSOP_out  out  1  first beat of TLP.
- txEOP_out  out  1  last beat of TLP.
- txReady_in  in  1  sink ready.

Behaviour:
- Reset values: wrPtr_out=0, all tx* outputs=0, f2cReady_out=0, state=IDLE, internal tlpCount=0, qwCount=0.
- A beat transfers when txValid_out & txReady_in. A source word transfers when f2cValid_in & f2cReady_out.
- f2cReady_out = (state==DATA) & txReady_in. It is combinational and never depends on f2cValid_in.
- States:
  - IDLE: if enable_in, go to WAIT_SPACE. Otherwise hold, with wrPtr and counters cleared to 0.
  - WAIT_SPACE: ring is full when wrPtr+1 (mod NUM_CHUNKS) == rdPtr_in, so one chunk always stays empty. Stall while full. When not full, go to HDR0. If enable_in drops here, go to IDLE.
  - HDR0: txValid=1, txSOP=1. txData = {DW1, DW0}, with DW0 = 32'h4000_0000 | 2*TLP_QWS and DW1 = {cfgBusDev_in, 8'h00, 4'hF, 4'hF}. Advance on handshake.
  - HDR1: txData = {32'h0, addr}. addr = (f2cBase_in + wrPtr*TLPS_PER_CHUNK*TLP_QWS + tlpCount*TLP_QWS) << 3, truncated to 32 bits. Advance on handshake.
  - DATA: txValid_out = f2cValid_in and txData_out = f2cData_in. Bubbles mid-TLP are permitted. qwCount increments per transfer. txEOP=1 when qwCount==TLP_QWS-1. On the EOP transfer, qwCount is cleared, then:
    - if tlpCount==TLPS_PER_CHUNK-1: clear tlpCount, go to MHDR0;
    - else: tlpCount++ and go to WAIT_SPACE if enable_in is high, IDLE if it is low.
  - MHDR0: 1-DW MWr header. DW0 = 32'h4000_0001, DW1 = {cfgBusDev_in, 8'h00, 4'h0, 4'hF}, SOP=1.
  - MHDR1: {32'h0, mtrBase_in<<3}.
  - MDATA: {32'h0, zero-extended wrPtr+1}, EOP=1. On handshake, wrPtr increments (wrapping mod NUM_CHUNKS). Go to WAIT_SPACE if enable_in is high, else IDLE.
- The ring-full check is made only at TLP boundaries (WAIT_SPACE). The host cannot free the chunk currently being written, so this is sufficient.
- Deasserting enable_in mid-TLP or mid-metrics-write completes that TLP; no truncated TLP is ever emitted.
- Entering IDLE with enable_in low clears wrPtr and tlpCount. A partially written chunk is abandoned and its wrPtr is never published.
- When txReady_in is low, txData/SOP/EOP/Valid hold stable. Outputs are registered or held; header beats do not depend on txReady_in.
- Latency: first HDR0 beat is valid 2 cycles after enable_in rises, given the ring is not full.
- Asynchronous rstn assertion mid-TLP drops everything immediately and returns all outputs to reset values.

Test Plan:
- Reset, enable=1, f2cBase=0, rdPtr=0, source always valid with counting data 0,1,2...; sink always ready -> first TLP: DW0=0x40000020, address 0x0, data 0..15. TLP 31 address 0xF80. Metrics MWr writes 0x1 to mtrBase<<3. wrPtr_out=1.
- Same setup, rdPtr held at 0 -> exactly 3 chunks (96 TLPs + 3 metrics writes) emitted, then WAIT_SPACE stall. Setting rdPtr=1 releases chunk 4 at address 0x3000. Its metrics value is 0 (wrap).
- txReady_in toggled 1/0 every cycle and source valid randomly -> stream content is identical to the first test. No beat lost or duplicated; outputs stable while ready is low.
- enable dropped at data QW 5 of TLP 2 -> TLP 2 completes (16 QWs, EOP), then IDLE with wrPtr=0. Re-enable restarts at address f2cBase<<3 with no metrics write for the aborted chunk.
- rstn pulsed low during HDR1 -> txValid_out=0 in the same cycle. After release, behaviour matches the first test from the start.
- cfgBusDev_in=0x0108 -> DW1 of a data TLP = 0x010800FF; DW1 of a metrics TLP = 0x0108000F.

Source files
------------

// File: rtl/f2c_dma_writer.sv
// f2c_dma_writer: FPGA->CPU DMA engine.
// Packs a 64-bit source stream into fixed-size MWr TLPs that fill a ring of
// chunks in host memory. After each completed chunk it posts the new write
// pointer to the host metrics buffer with a 1-DW MWr.
module f2c_dma_writer #(
    parameter int TLP_QWS        = 16,
    parameter int TLPS_PER_CHUNK = 32,
    parameter int NUM_CHUNKS     = 4,
    parameter int PTR_W          = $clog2(NUM_CHUNKS)
) (
    input  logic             clk_in,
    input  logic             rstn,
    input  logic [15:0]      cfgBusDev_in,
    input  logic             enable_in,
    input  logic [28:0]      f2cBase_in,
    input  logic [28:0]      mtrBase_in,
    input  logic [PTR_W-1:0] rdPtr_in,
    output logic [PTR_W-1:0] wrPtr_out,
    input  logic [63:0]      f2cData_in,
    input  logic             f2cValid_in,
    output logic             f2cReady_out,
    output logic [63:0]      txData_out,
    output logic             txValid_out,
    output logic             txSOP_out,
    output logic             txEOP_out,
    input  logic             txReady_in
);

    localparam int QW_W  = $clog2(TLP_QWS);
    localparam int TLP_W = $clog2(TLPS_PER_CHUNK);

    localparam logic [QW_W-1:0]  QW_LAST   = QW_W'(TLP_QWS - 1);
    localparam logic [TLP_W-1:0] TLP_LAST  = TLP_W'(TLPS_PER_CHUNK - 1);
    localparam logic [31:0]      CHUNK_QWS = 32'(TLPS_PER_CHUNK * TLP_QWS);
    localparam logic [31:0]      TLP_QWS32 = 32'(TLP_QWS);

    // Header DW0: Fmt=3DW-with-data MWr, length in DWs.
    localparam logic [31:0] DATA_DW0 = 32'h4000_0000 | 32'(2 * TLP_QWS);
    localparam logic [31:0] MTR_DW0  = 32'h4000_0001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_SPACE,
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_MHDR0,
        S_MHDR1,
        S_MDATA
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [TLP_W-1:0]   tlp_cnt_q, tlp_cnt_d;
    logic [QW_W-1:0]    qw_cnt_q, qw_cnt_d;

    logic [PTR_W-1:0]   wr_ptr_inc;
    logic               ring_full;
    logic [31:0]        qw_addr;
    logic [31:0]        byte_addr;
    logic               src_fire;

    // Ring bookkeeping: one chunk is always kept empty so full != empty.
    assign wr_ptr_inc = wr_ptr_q + PTR_W'(1);
    assign ring_full  = (wr_ptr_inc == rdPtr_in);

    // Host QW address of the current TLP; the byte address wraps at 32 bits.
    assign qw_addr   = {3'b000, f2cBase_in}
                     + (32'(wr_ptr_q) * CHUNK_QWS)
                     + (32'(tlp_cnt_q) * TLP_QWS32);
    assign byte_addr = qw_addr << 3;

    // In DATA a source word and a TX beat are the same handshake.
    assign src_fire = f2cValid_in & txReady_in;

    assign wrPtr_out = wr_ptr_q;

    // Next-state, counter update and TX/source handshake outputs.
    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        tlp_cnt_d    = tlp_cnt_q;
        qw_cnt_d     = qw_cnt_q;
        txData_out   = 64'd0;
        txValid_out  = 1'b0;
        txSOP_out    = 1'b0;
        txEOP_out    = 1'b0;
        f2cReady_out = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable_in) begin
                    state_d = S_WAIT_SPACE;
                end
            end

            S_WAIT_SPACE: begin
                // Space is only checked at TLP boundaries; the host can never
                // free the chunk currently being filled.
                if (!enable_in) begin
                    state_d = S_IDLE;
                end else if (!ring_full) begin
                    state_d = S_HDR0;
                end
            end

            S_HDR0: begin
                txValid_out = 1'b1;
                txSOP_out   = 1'b1;
                txData_out  = {cfgBusDev_in, 8'h00, 4'hF, 4'hF, DATA_DW0};
                if (txReady_in) begin
                    state_d = S_HDR1;
                end
            end

            S_HDR1: begin
                txValid_out = 1'b1;
                txData_out  = {32'h0, byte_addr};
                if (txReady_in) begin
                    state_d = S_DATA;
                end
            end

            S_DATA: begin
                // Source passes straight through; bubbles are allowed mid-TLP.
                f2cReady_out = txReady_in;
                txValid_out  = f2cValid_in;
                txData_out   = f2cData_in;
                txEOP_out    = (qw_cnt_q == QW_LAST);
                if (src_fire) begin
                    if (qw_cnt_q == QW_LAST) begin
                        qw_cnt_d = '0;
                        if (tlp_cnt_q == TLP_LAST) begin
                            tlp_cnt_d = '0;
                            state_d   = S_MHDR0;
                        end else begin
                            tlp_cnt_d = tlp_cnt_q + TLP_W'(1);
                            state_d   = enable_in ? S_WAIT_SPACE : S_IDLE;
                        end
                    end else begin
                        qw_cnt_d = qw_cnt_q + QW_W'(1);
                    end
                end
            end

            S_MHDR0: begin
                txValid_out = 1'b1;
                txSOP_out   = 1'b1;
                txData_out  = {cfgBusDev_in, 8'h00, 4'h0, 4'hF, MTR_DW0};
                if (txReady_in) begin
                    state_d = S_MHDR1;
                end
            end

            S_MHDR1: begin
                txValid_out = 1'b1;
                txData_out  = {32'h0, mtrBase_in, 3'b000};
                if (txReady_in) begin
                    state_d = S_MDATA;
                end
            end

            S_MDATA: begin
                // Publishes the pointer the chunk completion advances to.
                txValid_out = 1'b1;
                txEOP_out   = 1'b1;
                txData_out  = {32'h0, 32'(wr_ptr_inc)};
                if (txReady_in) begin
                    wr_ptr_d = wr_ptr_inc;
                    state_d  = enable_in ? S_WAIT_SPACE : S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Anything landing in IDLE abandons the partial chunk: its pointer is
        // never published and the next enable restarts at the ring base.
        if (state_d == S_IDLE) begin
            wr_ptr_d  = '0;
            tlp_cnt_d = '0;
            qw_cnt_d  = '0;
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            tlp_cnt_q <= '0;
            qw_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            tlp_cnt_q <= tlp_cnt_d;
            qw_cnt_q  <= qw_cnt_d;
        end
    end

endmodule
